// File: rtl/axis_pkg.sv
// Shared AXI-Stream types for the NoC injection path: flit/ID widths,
// master/slave channel bundles and the serializer state encoding.
package axis_pkg;

   localparam int AXIS_DATA_WIDTH = 32;
   localparam int AXIS_ID_WIDTH   = 4;

   typedef struct packed {
      logic                       TVALID;
      logic [AXIS_DATA_WIDTH-1:0] TDATA;
      logic                       TLAST;
      logic [AXIS_ID_WIDTH-1:0]   TID;
   } axis_mosi_t;

   typedef struct packed {
      logic TREADY;
   } axis_miso_t;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } ser_state_t;

endpackage

// File: rtl/stream_serializer.sv
// Wide-to-narrow AXI-Stream transmitter: one wide word per handshake is sent
// as a packet of up to RATIO flits, LS flit first, TLAST on the final flit.
module stream_serializer
   import axis_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int IN_WIDTH   = 128,
   parameter  int ID_WIDTH   = 4,
   localparam int RATIO      = IN_WIDTH / DATA_WIDTH,
   localparam int LEN_WIDTH  = $clog2(RATIO + 1)
) (
   input  logic                 ACLK,
   input  logic                 ARESETn,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [IN_WIDTH-1:0]  in_data_i,
   input  logic [LEN_WIDTH-1:0] in_len_i,
   input  logic [ID_WIDTH-1:0]  in_id_i,
   output axis_mosi_t           out_mosi_o,
   input  axis_miso_t           out_miso_i
);

   localparam int CNT_WIDTH = $clog2(RATIO);

   if (RATIO < 2) begin : g_bad_ratio
      $error("stream_serializer: IN_WIDTH/DATA_WIDTH must be at least 2");
   end
   if (IN_WIDTH % DATA_WIDTH != 0) begin : g_bad_multiple
      $error("stream_serializer: IN_WIDTH must be a multiple of DATA_WIDTH");
   end
   if (DATA_WIDTH != AXIS_DATA_WIDTH || ID_WIDTH != AXIS_ID_WIDTH) begin : g_bad_pkg
      $error("stream_serializer: widths must match axis_pkg");
   end

   ser_state_t           state_q;
   logic [IN_WIDTH-1:0]  shift_q;
   logic [LEN_WIDTH-1:0] len_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [ID_WIDTH-1:0]  id_q;

   logic [LEN_WIDTH-1:0] eff_len_d;
   logic                 last_flit;
   logic                 in_hs;

   always_comb begin
      // 0 and anything above RATIO both mean a full-length packet
      if (in_len_i == '0 || in_len_i > LEN_WIDTH'(RATIO)) begin
         eff_len_d = LEN_WIDTH'(RATIO);
      end else begin
         eff_len_d = in_len_i;
      end

      last_flit  = (state_q == SEND) && (LEN_WIDTH'(cnt_q) == len_q - LEN_WIDTH'(1));
      in_ready_o = ARESETn & ((state_q == IDLE) | (last_flit & out_miso_i.TREADY));
      in_hs      = in_valid_i & in_ready_o;

      out_mosi_o.TVALID = (state_q == SEND);
      out_mosi_o.TDATA  = shift_q[DATA_WIDTH-1:0];
      out_mosi_o.TLAST  = last_flit;
      out_mosi_o.TID    = id_q;
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state_q <= IDLE;
         shift_q <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         id_q    <= '0;
      end else if (in_hs) begin
         // covers both IDLE accept and the back-to-back reload on the last flit
         state_q <= SEND;
         shift_q <= in_data_i;
         len_q   <= eff_len_d;
         cnt_q   <= '0;
         id_q    <= in_id_i;
      end else if (state_q == SEND && out_miso_i.TREADY) begin
         if (last_flit) begin
            state_q <= IDLE;
         end else begin
            shift_q <= shift_q >> DATA_WIDTH;
            cnt_q   <= cnt_q + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_stream_serializer.sv
// Self-checking bench for stream_serializer: a flit queue predicts every
// output flit, TVALID and in_ready_o from the packet-level rules.
module tb_stream_serializer;
   import axis_pkg::*;

   localparam int RATIO = 4;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
      logic [3:0]  id;
   } flit_t;

   logic         ACLK = 1'b0;
   logic         ARESETn;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [2:0]   in_len;
   logic [3:0]   in_id;
   axis_mosi_t   mosi;
   axis_miso_t   miso;

   int    total = 0;
   int    bad   = 0;
   flit_t q[$];
   logic  after_reset = 1'b0;
   logic  stalled     = 1'b0;
   flit_t stall_flit;
   logic  accepted;

   always #5 ACLK = ~ACLK;

   stream_serializer #(.DATA_WIDTH(32), .IN_WIDTH(128), .ID_WIDTH(4)) dut (
      .ACLK       (ACLK),
      .ARESETn    (ARESETn),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .in_data_i  (in_data),
      .in_len_i   (in_len),
      .in_id_i    (in_id),
      .out_mosi_o (mosi),
      .out_miso_i (miso)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock: drive inputs, check outputs against the queue, advance the model.
   task automatic step(input logic v, input logic [127:0] d, input logic [2:0] l,
                       input logic [3:0] id, input logic rdy, input logic rn);
      logic exp_vld, exp_rdy, hs_in, hs_out;
      int   eff;
      @(negedge ACLK);
      in_valid     = v;
      in_data      = d;
      in_len       = l;
      in_id        = id;
      miso.TREADY  = rdy;
      ARESETn      = rn;
      #1;
      exp_vld = (q.size() > 0);
      exp_rdy = rn && (q.size() == 0 || (q.size() == 1 && rdy));
      check("tvalid", 128'(mosi.TVALID), 128'(exp_vld));
      check("in_ready", 128'(in_ready), 128'(exp_rdy));
      if (exp_vld) begin
         check("tdata", 128'(mosi.TDATA), 128'(q[0].data));
         check("tlast", 128'(mosi.TLAST), 128'(q[0].last));
         check("tid", 128'(mosi.TID), 128'(q[0].id));
      end
      if (stalled && !after_reset) begin
         check("stable", 128'({mosi.TDATA, mosi.TLAST, mosi.TID}), 128'(stall_flit));
      end
      if (after_reset) begin
         check("rst_tdata", 128'(mosi.TDATA), 128'(0));
         check("rst_tid", 128'(mosi.TID), 128'(0));
         check("rst_tlast", 128'(mosi.TLAST), 128'(0));
      end
      stalled    = exp_vld && !rdy;
      stall_flit = exp_vld ? q[0] : '0;
      hs_in      = v && exp_rdy;
      hs_out     = exp_vld && rdy;
      accepted   = hs_in;
      @(posedge ACLK);
      if (!rn) begin
         q.delete();
         after_reset = 1'b1;
         stalled     = 1'b0;
      end else begin
         after_reset = 1'b0;
         if (hs_out) void'(q.pop_front());
         if (hs_in) begin
            eff = (l == 0 || l > RATIO) ? RATIO : int'(l);
            for (int k = 0; k < eff; k++) begin
               q.push_back('{data: d[k*32 +: 32], last: (k == eff - 1), id: id});
            end
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b1, 1'b1);
   endtask

   initial begin
      logic [127:0] words [2];
      int           idx;

      ARESETn = 1'b0; in_valid = 1'b0; in_data = '0; in_len = '0; in_id = '0;
      miso.TREADY = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0, 1'b0, 1'b0);
      idle(2);

      step(1'b1, 128'h44444444_33333333_22222222_11111111, 3'd0, 4'd3, 1'b1, 1'b1);
      idle(6);
      step(1'b1, 128'hdddddddd_cccccccc_bbbbbbbb_aaaaaaaa, 3'd2, 4'd1, 1'b1, 1'b1);
      idle(4);
      step(1'b1, 128'h0 | 32'h5a5a5a5a, 3'd1, 4'd9, 1'b1, 1'b1);
      idle(3);
      step(1'b1, 128'h0f0f0f0f_0e0e0e0e_0d0d0d0d_0c0c0c0c, 3'd7, 4'd7, 1'b1, 1'b1);
      idle(6);

      // back-to-back: valid held high across two words
      words[0] = 128'h18181818_17171717_16161616_15151515;
      words[1] = 128'h28282828_27272727_26262626_25252525;
      idx = 0;
      for (int i = 0; i < 20 && idx < 2; i++) begin
         step(1'b1, words[idx], 3'd0, 4'(idx + 2), 1'b1, 1'b1);
         if (accepted) idx++;
      end
      check("b2b_accepts", 128'(idx), 128'(2));
      idle(10);

      // reset after the second flit of a four-flit packet
      step(1'b1, 128'h99999999_88888888_77777777_66666666, 3'd4, 4'd6, 1'b1, 1'b1);
      idle(2);
      step(1'b0, '0, '0, '0, 1'b1, 1'b0);
      idle(2);
      step(1'b1, 128'hcafef00d_deadbeef_01234567_89abcdef, 3'd0, 4'd4, 1'b1, 1'b1);
      idle(6);

      for (int i = 0; i < 600; i++) begin
         step(($urandom % 4) != 0,
              {$urandom, $urandom, $urandom, $urandom},
              3'($urandom % 8), 4'($urandom % 16),
              1'($urandom % 2),
              ($urandom % 64) != 0);
      end

      for (int i = 0; i < 40 && q.size() > 0; i++) idle(1);
      check("drain", 128'(q.size()), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
